// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, register offsets of the
// accelerator register file, and the master FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] REG0 = 32'h0000_0000;
    localparam logic [31:0] REG1 = 32'h0000_0004;
    localparam logic [31:0] REG2 = 32'h0000_0008;
    localparam logic [31:0] REG3 = 32'h0000_000C;
    localparam logic [31:0] REG4 = 32'h0000_0010;
    localparam logic [31:0] REG5 = 32'h0000_0014;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } master_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: one single-beat read or write at a time, driven by a
// CMD valid/ready request and answered by a buffered RSP valid/ready response.
//
// Handshake rule on every channel (CMD, RSP, AW, W, B, AR, R): a transfer
// happens on the rising ACLK edge where VALID and READY are both high. VALID
// is decoded from registered state only (never from READY) and, once high,
// holds with a stable payload until that transfer edge.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    // command from requester
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
    // response to requester
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [DATA_WIDTH-1:0]   RSP_RDATA,
    output logic [1:0]              RSP_RESP,
    output logic                    RSP_ERR,
    // write address channel
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    // write data channel
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    // write response channel
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    // read address channel
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    // read data channel
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY,
    // observability
    output master_state_t           DBG_STATE
);

    master_state_t state_q, state_d;
    logic          aw_done, w_done;
    logic          cmd_hs, aw_hs, w_hs;

    assign cmd_hs = CMD_VALID & CMD_READY;
    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;

    // Handshake outputs are pure decodes of state and the done flags.
    assign CMD_READY = (state_q == IDLE);
    assign AWVALID   = (state_q == WR_REQ) & ~aw_done;
    assign WVALID    = (state_q == WR_REQ) & ~w_done;
    assign BREADY    = (state_q == WR_RESP);
    assign ARVALID   = (state_q == RD_REQ);
    assign RREADY    = (state_q == RD_RESP);
    assign RSP_VALID = (state_q == RSP);
    assign RSP_ERR   = RSP_RESP[1];
    assign WSTRB     = '1;
    assign AWPROT    = 3'b000;
    assign ARPROT    = 3'b000;
    assign DBG_STATE = state_q;

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state; a handshake completing this cycle counts as done so that
    // AW/W finishing together (or the second one finishing) moves on at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_hs) state_d = CMD_WRITE ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done | aw_hs) & (w_done | w_hs)) state_d = WR_RESP;
            WR_RESP: if (BVALID) state_d = RSP;
            RD_REQ:  if (ARREADY) state_d = RD_RESP;
            RD_RESP: if (RVALID) state_d = RSP;
            RSP:     if (RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-channel completion flags for the write request phase.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (cmd_hs) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state_q == WR_REQ) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // AXI request payload registers, loaded when a command is accepted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            AWADDR <= '0;
            WDATA  <= '0;
            ARADDR <= '0;
        end else if (cmd_hs) begin
            if (CMD_WRITE) begin
                AWADDR <= CMD_ADDR;
                WDATA  <= CMD_WDATA;
            end else begin
                ARADDR <= CMD_ADDR;
            end
        end
    end

    // Response capture register, held stable through the RSP state.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            RSP_RDATA <= '0;
            RSP_RESP  <= RESP_OKAY;
        end else if (state_q == WR_RESP && BVALID) begin
            RSP_RDATA <= '0;
            RSP_RESP  <= BRESP;
        end else if (state_q == RD_RESP && RVALID) begin
            RSP_RDATA <= RDATA;
            RSP_RESP  <= RRESP;
        end
    end

endmodule
